// File: rtl/dzcpu_useq_pkg.sv
// Shared ucode definitions for the DZCPU microsequencer, LUTs and ROM:
// uop word layout, flow-code values and sequencer state encoding.
package dzcpu_useq_pkg;

  localparam int ADDR_W = 8;
  localparam int FLOW_W = 4;
  localparam int BODY_W = 9;
  localparam int UOP_W  = FLOW_W + BODY_W;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DECODE   = 2'd1,
    S_EXEC     = 2'd2,
    S_CBDECODE = 2'd3
  } state_e;

  // Codes 11..15 are reserved and behave like F_NOP.
  typedef enum logic [FLOW_W-1:0] {
    F_OP           = 4'd0,
    F_INC          = 4'd1,
    F_EOF          = 4'd2,
    F_INC_EOF      = 4'd3,
    F_EOF_FU       = 4'd4,
    F_INC_EOF_FU   = 4'd5,
    F_INC_EOF_Z    = 4'd6,
    F_INC_EOF_NZ   = 4'd7,
    F_UPDATE_FLAGS = 4'd8,
    F_NOP          = 4'd9,
    F_JCB          = 4'd10
  } flow_e;

endpackage

// File: rtl/dzcpu_useq_ctr.sv
// Per-flow uop counter; 'last' flags that the uop now executing is the
// LIMIT-th one of the current flow.
module dzcpu_useq_ctr #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  // Clear has priority so an ending uop restarts the count cleanly.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (inc)   cnt_q <= cnt_q + W'(1);
  end

  assign last = (cnt_q == LAST);
endmodule

// File: rtl/dzcpu_useq.sv
// DZCPU ucode sequencer: fetch opcode, map through the LUTs, step the uPC
// through the ucode ROM and decode each uop's flow code.
// Optional interrupt entry at end of flow: define DZCPU_USEQ_INT_EN.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter logic [7:0] INT_FLOW_IDX = 8'd165,
  parameter int         UOP_LIMIT    = 32
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMemData,
  input  logic              iMemValid,
  input  logic              iStall,
  input  logic              iFlagZ,
  output logic [7:0]        oLutMop,
  input  logic [7:0]        iLutIdx,
  output logic [7:0]        oCbMop,
  input  logic [7:0]        iCbIdx,
  output logic [ADDR_W-1:0] oRomAddr,
  input  logic [UOP_W-1:0]  iUop,
  output logic              oUopValid,
  output logic [BODY_W-1:0] oUopBody,
  output logic              oIncPc,
  output logic              oFlagUpdate,
  output logic              oFetch,
  output logic              oEof,
  output logic              oUcodeErr,
  input  logic              iIntReq,
  input  logic              iIme
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [7:0]        op_q, op_d, cb_q, cb_d;
  logic              err_q, err_d;
  logic              ctr_clr, ctr_inc, ctr_last;
  logic              adv, fin;
  logic [FLOW_W-1:0] fcode;

`ifndef DZCPU_USEQ_INT_EN
  logic unused_int;
  assign unused_int = iIntReq | iIme;
`endif

  assign fcode    = iUop[UOP_W-1:BODY_W];
  assign oUopBody = iUop[BODY_W-1:0];
  assign oRomAddr = upc_q;
  assign oLutMop  = op_q;
  assign oCbMop   = cb_q;
  assign oUcodeErr = err_q;

  dzcpu_useq_ctr #(.LIMIT(UOP_LIMIT)) u_ctr (
    .clk  (iClock),
    .rst  (iReset),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .last (ctr_last)
  );

  // State register; reset wins from any state, including mid-flow.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_FETCH;
      upc_q   <= '0;
      op_q    <= 8'h00;
      cb_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      op_q    <= op_d;
      cb_q    <= cb_d;
      err_q   <= err_d;
    end
  end

  // Next state and per-cycle controls; pulses are held low during reset.
  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    op_d        = op_q;
    cb_d        = cb_q;
    err_d       = err_q;
    oFetch      = 1'b0;
    oUopValid   = 1'b0;
    oIncPc      = 1'b0;
    oFlagUpdate = 1'b0;
    oEof        = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    adv         = 1'b0;
    fin         = 1'b0;
    if (!iReset) begin
      unique case (state_q)
        S_FETCH: begin
          oFetch = 1'b1;
          if (iMemValid) begin
            op_d    = iMemData;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          upc_d   = iLutIdx;
          ctr_clr = 1'b1;
          state_d = S_EXEC;
        end
        S_CBDECODE: begin
          upc_d   = iCbIdx;
          ctr_clr = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (!iStall) begin
            oUopValid = 1'b1;
            ctr_inc   = 1'b1;
            case (fcode)
              F_OP:           adv = 1'b1;
              F_INC:          begin oIncPc = 1'b1; adv = 1'b1; end
              F_EOF:          fin = 1'b1;
              F_INC_EOF:      begin oIncPc = 1'b1; fin = 1'b1; end
              F_EOF_FU:       begin oFlagUpdate = 1'b1; fin = 1'b1; end
              F_INC_EOF_FU:   begin oIncPc = 1'b1; oFlagUpdate = 1'b1; fin = 1'b1; end
              F_INC_EOF_Z:    begin oIncPc = 1'b1; fin = iFlagZ; adv = ~iFlagZ; end
              F_INC_EOF_NZ:   begin oIncPc = 1'b1; fin = ~iFlagZ; adv = iFlagZ; end
              F_UPDATE_FLAGS: begin oFlagUpdate = 1'b1; adv = 1'b1; end
              F_JCB: begin
                oIncPc  = 1'b1;
                cb_d    = iMemData;
                state_d = S_CBDECODE;
              end
              default:        adv = 1'b1;
            endcase
            if (fin) begin
              oEof    = 1'b1;
              ctr_clr = 1'b1;
              state_d = S_FETCH;
`ifdef DZCPU_USEQ_INT_EN
              if (iIntReq && iIme) begin
                state_d = S_EXEC;
                upc_d   = INT_FLOW_IDX;
              end
`endif
            end else if (adv) begin
              upc_d = upc_q + 8'd1;
              // Runaway flow: abort to fetch without an end-of-flow pulse.
              if (ctr_last) begin
                err_d   = 1'b1;
                ctr_clr = 1'b1;
                state_d = S_FETCH;
              end
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed flows plus randomized
// stimulus against a cycle-level behavioural model with bench-held LUT/ROM.
module tb_dzcpu_useq;
  localparam int LIMIT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1, mv = 1'b0, st = 1'b0, zf = 1'b0, irq = 1'b0, ime = 1'b0;
  logic [7:0]  md = 8'h00;
  logic [7:0]  lutmop, lutidx, cbmop, cbidx, romaddr;
  logic [12:0] uop;
  logic [8:0]  body;
  logic        uvalid, incpc, fupd, fetch, eof, uerr;

  logic [12:0] rom   [256];
  logic [7:0]  lut   [256];
  logic [7:0]  cblut [256];

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 fetch, 1 decode, 2 execute, 3 CB decode.
  int         m_ph = 0, m_cnt = 0;
  logic [7:0] m_upc = 8'h00, m_op = 8'h00, m_cb = 8'h00;
  logic       m_err = 1'b0;

  always #5 clk = ~clk;

  always_comb uop    = rom[romaddr];
  always_comb lutidx = lut[lutmop];
  always_comb cbidx  = cblut[cbmop];

  dzcpu_useq dut (
    .iClock(clk), .iReset(rst), .iMemData(md), .iMemValid(mv), .iStall(st),
    .iFlagZ(zf), .oLutMop(lutmop), .iLutIdx(lutidx), .oCbMop(cbmop),
    .iCbIdx(cbidx), .oRomAddr(romaddr), .iUop(uop), .oUopValid(uvalid),
    .oUopBody(body), .oIncPc(incpc), .oFlagUpdate(fupd), .oFetch(fetch),
    .oEof(eof), .oUcodeErr(uerr), .iIntReq(irq), .iIme(ime)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Predict this cycle's outputs from the model, compare, then step the model.
  task automatic model_cycle();
    logic       e_fetch, e_valid, e_inc, e_fu, e_eof, ends;
    logic [12:0] w;
    int         code;
    int         n_ph, n_cnt;
    logic [7:0] n_upc, n_op, n_cb;
    logic       n_err;
    e_fetch = 0; e_valid = 0; e_inc = 0; e_fu = 0; e_eof = 0;
    n_ph = m_ph; n_cnt = m_cnt; n_upc = m_upc; n_op = m_op; n_cb = m_cb; n_err = m_err;
    w = rom[m_upc];
    code = int'(w[12:9]);
    if (rst) begin
      n_ph = 0; n_cnt = 0; n_upc = 0; n_op = 0; n_cb = 0; n_err = 0;
    end else if (m_ph == 0) begin
      e_fetch = 1;
      if (mv) begin n_op = md; n_ph = 1; end
    end else if (m_ph == 1) begin
      n_upc = lut[m_op]; n_cnt = 0; n_ph = 2;
    end else if (m_ph == 3) begin
      n_upc = cblut[m_cb]; n_cnt = 0; n_ph = 2;
    end else if (!st) begin
      e_valid = 1;
      n_cnt = m_cnt + 1;
      e_inc = code inside {1, 3, 5, 6, 7, 10};
      e_fu  = code inside {4, 5, 8};
      ends  = (code inside {2, 3, 4, 5}) || (code == 6 && zf) || (code == 7 && !zf);
      if (code == 10) begin
        n_cb = md; n_ph = 3;
      end else if (ends) begin
        e_eof = 1; n_ph = 0;
      end else begin
        n_upc = m_upc + 8'd1;
        if (n_cnt == LIMIT) begin n_err = 1; n_ph = 0; end
      end
    end
    check("fetch", fetch, e_fetch);
    check("uop_valid", uvalid, e_valid);
    check("inc_pc", incpc, e_inc);
    check("flag_upd", fupd, e_fu);
    check("eof", eof, e_eof);
    if (!rst) begin
      check("lut_mop", lutmop, m_op);
      check("cb_mop", cbmop, m_cb);
      check("ucode_err", uerr, m_err);
      if (m_ph == 2) begin
        check("rom_addr", romaddr, m_upc);
        check("uop_body", body, w[8:0]);
      end
    end
    m_ph = n_ph; m_cnt = n_cnt; m_upc = n_upc; m_op = n_op; m_cb = n_cb; m_err = n_err;
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic s, input logic z);
    @(negedge clk);
    rst = r; mv = v; md = d; st = s; zf = z;
    #1;
    model_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]   = {4'($urandom_range(0, 15)), 9'($urandom)};
      lut[i]   = 8'($urandom);
      cblut[i] = 8'($urandom);
    end
    // Directed table entries.
    lut[8'h00] = 8'd0;   rom[0]  = {4'd3, 9'h0AA};
    lut[8'h20] = 8'd19;  rom[19] = {4'd6, 9'h013};
    rom[20] = {4'd0, 9'h014}; rom[21] = {4'd0, 9'h015}; rom[22] = {4'd2, 9'h016};
    lut[8'h30] = 8'd15;  rom[15] = {4'd10, 9'h00F};
    cblut[8'h7C] = 8'd16; rom[16] = {4'd2, 9'h010};
    lut[8'h40] = 8'd50;  rom[50] = {4'd1, 9'h032}; rom[51] = {4'd2, 9'h033};
    lut[8'h50] = 8'd100;
    for (int i = 100; i < 132; i++) rom[i] = {4'd0, 9'(i)};

    // Reset, then opcode 00 -> single INC_EOF uop.
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    check("rst_fetch_low", fetch, 0);
    cyc(0, 1, 8'h00, 0, 0);
    check("first_fetch", fetch, 1);
    cyc(0, 0, 8'h00, 0, 0);
    check("decode_no_fetch", fetch, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("op00_inc", incpc, 1);
    check("op00_eof", eof, 1);
    cyc(0, 0, 8'h00, 0, 0);
    check("op00_back_fetch", fetch, 1);

    // INC_EOF_Z at 19 with Z=1 ends there.
    cyc(0, 1, 8'h20, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("z1_addr", romaddr, 19);
    check("z1_eof", eof, 1);
    // Same flow with Z=0 runs 19..22.
    cyc(0, 1, 8'h20, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("z0_no_eof", eof, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("z0_addr20", romaddr, 20);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("z0_addr22", romaddr, 22);
    check("z0_eof22", eof, 1);

    // JCB at 15 with CB opcode 7C -> flow at 16.
    cyc(0, 1, 8'h30, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h7C, 0, 0);
    check("jcb_inc", incpc, 1);
    cyc(0, 0, 8'h00, 0, 0);
    check("cb_mop", cbmop, 8'h7C);
    cyc(0, 0, 8'h00, 0, 0);
    check("cb_addr16", romaddr, 16);
    cyc(0, 0, 8'h00, 0, 0);
    check("cb_hold", cbmop, 8'h7C);

    // Stall three cycles on uPC 50.
    cyc(0, 1, 8'h40, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, 1, 0);
      check("stall_addr", romaddr, 50);
      check("stall_valid", uvalid, 0);
      check("stall_inc", incpc, 0);
    end
    cyc(0, 0, 8'h00, 0, 0);
    check("unstall_inc", incpc, 1);
    cyc(0, 0, 8'h00, 0, 0);
    check("resume_51", romaddr, 51);

    // Runaway flow of OP uops trips the limit.
    cyc(0, 1, 8'h50, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < LIMIT; i++) cyc(0, 0, 8'h00, 0, 0);
    check("limit_no_eof", eof, 0);
    cyc(0, 1, 8'h50, 0, 0);
    check("limit_fetch", fetch, 1);
    check("limit_err", uerr, 1);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("midrst_fetch", fetch, 1);
    check("midrst_err", uerr, 0);

    // Randomized traffic; interrupt inputs toggled to show they are ignored.
    for (int i = 0; i < 4000; i++) begin
      irq = 1'($urandom);
      ime = 1'($urandom);
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom),
          1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
